// File: rtl/jtag_scan_seq_if.sv
// ============================================================================
// Module   : jtag_scan_seq_if
// Purpose  : Command/response bundle between a host and jtag_scan_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface jtag_scan_seq_if #(
    parameter int W  = 32,
    parameter int LW = 6
);
    logic          req;
    logic          cmd_rst;
    logic [LW-1:0] len;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  rdata;

    modport master (
        output req, cmd_rst, len, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  req, cmd_rst, len, wdata,
        output busy, done, rdata
    );
endinterface

`default_nettype wire

// File: rtl/jtag_scan_seq.sv
// ============================================================================
// Module   : jtag_scan_seq
// Purpose  : One DR scan per command into a BSCAN-style user chain
//            (optional TAP reset, CAPTURE, SHIFT len bits, UPDATE).
//            Define JTAG_SCAN_IDLE_EN to add RUNTEST cycles after UPDATE.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jtag_scan_seq #(
    parameter int W           = 32,
    parameter int LW          = 6,
    parameter int RST_CYCLES  = 4,
    parameter int IDLE_CYCLES = 2
) (
    input  wire logic         clk_p,
    input  wire logic         RESET,
    jtag_scan_seq_if.slave    cmd,
    output logic              TAP_RESET,
    output logic              SEL,
    output logic              CAPTURE,
    output logic              SHIFT,
    output logic              UPDATE,
    output logic              RUNTEST,
    output logic              TDI,
    input  wire logic         TDO
);

    localparam int PW = $clog2(RST_CYCLES + IDLE_CYCLES + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRST    = 3'd1,
        S_CAPT    = 3'd2,
        S_GAP     = 3'd3,
        S_SHIFT   = 3'd4,
        S_UPD     = 3'd5,
        S_IDLE_RT = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    state_t        state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] bit_cnt;
    logic [PW-1:0] ph_cnt;
    logic [W-1:0]  wsh;
    logic [W-1:0]  sreg;
    logic [LW-1:0] len_clamped;

    assign len_clamped = (cmd.len > LW'(W)) ? LW'(W) : cmd.len;

    always_ff @(posedge clk_p) begin
        if (RESET) begin
            state      <= S_IDLE;
            len_q      <= '0;
            bit_cnt    <= '0;
            ph_cnt     <= '0;
            wsh        <= '0;
            sreg       <= '0;
            cmd.busy   <= 1'b0;
            cmd.done   <= 1'b0;
            cmd.rdata  <= '0;
            TAP_RESET  <= 1'b0;
            SEL        <= 1'b0;
            CAPTURE    <= 1'b0;
            SHIFT      <= 1'b0;
            UPDATE     <= 1'b0;
            RUNTEST    <= 1'b0;
            TDI        <= 1'b0;
        end else begin
            // One-cycle strobes fall back to 0 unless the next state raises them.
            cmd.done <= 1'b0;
            CAPTURE  <= 1'b0;
            UPDATE   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd.req) begin
                        len_q    <= len_clamped;
                        wsh      <= cmd.wdata;
                        sreg     <= '0;
                        bit_cnt  <= '0;
                        ph_cnt   <= '0;
                        cmd.busy <= 1'b1;
                        if (cmd.cmd_rst) begin
                            state     <= S_TRST;
                            TAP_RESET <= 1'b1;
                        end else begin
                            state   <= S_CAPT;
                            SEL     <= 1'b1;
                            CAPTURE <= 1'b1;
                        end
                    end
                end

                S_TRST: begin
                    if (ph_cnt == PW'(RST_CYCLES - 1)) begin
                        state     <= S_CAPT;
                        TAP_RESET <= 1'b0;
                        SEL       <= 1'b1;
                        CAPTURE   <= 1'b1;
                        ph_cnt    <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end
                end

                S_CAPT: begin
                    state <= S_GAP;
                end

                S_GAP: begin
                    if (len_q != '0) begin
                        state <= S_SHIFT;
                        SHIFT <= 1'b1;
                        TDI   <= wsh[0];
                        wsh   <= wsh >> 1;
                    end else begin
                        state  <= S_UPD;
                        UPDATE <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    // TDO of shift cycle k lands in bit k; bits >= len stay 0.
                    sreg <= sreg | (W'(TDO) << bit_cnt);
                    if (bit_cnt == len_q - LW'(1)) begin
                        state  <= S_UPD;
                        SHIFT  <= 1'b0;
                        TDI    <= 1'b0;
                        UPDATE <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + LW'(1);
                        TDI     <= wsh[0];
                        wsh     <= wsh >> 1;
                    end
                end

                S_UPD: begin
                    SEL <= 1'b0;
`ifdef JTAG_SCAN_IDLE_EN
                    state   <= S_IDLE_RT;
                    RUNTEST <= 1'b1;
                    ph_cnt  <= '0;
`else
                    state     <= S_FIN;
                    cmd.done  <= 1'b1;
                    cmd.busy  <= 1'b0;
                    cmd.rdata <= sreg;
`endif
                end

`ifdef JTAG_SCAN_IDLE_EN
                S_IDLE_RT: begin
                    if (ph_cnt == PW'(IDLE_CYCLES - 1)) begin
                        state     <= S_FIN;
                        RUNTEST   <= 1'b0;
                        cmd.done  <= 1'b1;
                        cmd.busy  <= 1'b0;
                        cmd.rdata <= sreg;
                    end else begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end
                end
`endif

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtag_scan_seq.sv
// ============================================================================
// Module   : tb_jtag_scan_seq
// Purpose  : Vector-table bench for jtag_scan_seq plus hand-written corner
//            sequences (request while busy, abort, request held over done).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jtag_scan_seq;

    localparam int W  = 32;
    localparam int LW = 6;
`ifdef JTAG_SCAN_IDLE_EN
    localparam int IDLE_ADD = 2;
`else
    localparam int IDLE_ADD = 0;
`endif

    typedef struct {
        logic          crst;
        logic [LW-1:0] ln;
        logic [W-1:0]  wd;
        bit            loopm;
        logic [W-1:0]  seq;
        logic [W-1:0]  exp_rd;
        int            exp_lat;
        int            exp_shift;
        int            exp_trst;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tap_reset, sel, capture, shift, update, runtest, tdi, tdo;

    always #5 clk = ~clk;

    jtag_scan_seq_if #(.W(W), .LW(LW)) bus ();

    jtag_scan_seq #(
        .W(W), .LW(LW), .RST_CYCLES(4), .IDLE_CYCLES(2)
    ) dut (
        .clk_p     (clk),
        .RESET     (rst),
        .cmd       (bus),
        .TAP_RESET (tap_reset),
        .SEL       (sel),
        .CAPTURE   (capture),
        .SHIFT     (shift),
        .UPDATE    (update),
        .RUNTEST   (runtest),
        .TDI       (tdi),
        .TDO       (tdo)
    );

    // Chain model: either TDI looped back through one flop, or a fixed bit
    // sequence indexed by shift cycle (TDO forced high outside SHIFT).
    bit           loop_mode = 1'b0;
    logic [W-1:0] tdo_seq   = '0;
    logic         tdo_reg   = 1'b0;
    int           k         = 0;

    always @(posedge clk) begin
        tdo_reg <= tdi;
        if (shift) k <= k + 1;
        else       k <= 0;
    end

    always_comb begin
        tdo = 1'b1;
        if (loop_mode)  tdo = tdo_reg;
        else if (shift) tdo = tdo_seq[k[4:0]];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus.busy, bus.done, bus.rdata, tap_reset, sel, capture,
                 shift, update, runtest, tdi};
    endfunction

    int   o_lat, o_shift, o_cap, o_upd, o_trst, o_rt, o_dones, o_proto, o_busy1;
    logic o_abort_outs;

    task automatic run_scan(input logic crst, input logic [LW-1:0] ln,
                            input logic [W-1:0] wd, input int repulse_at,
                            input int abort_at);
        int tail;
        tail = (repulse_at > 0) ? 25 : 2;
        o_lat = -1; o_shift = 0; o_cap = 0; o_upd = 0; o_trst = 0; o_rt = 0;
        o_dones = 0; o_proto = 0; o_busy1 = 0; o_abort_outs = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.cmd_rst = crst; bus.len = ln; bus.wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (c == 1) o_busy1 = int'(bus.busy);
            o_trst  += int'(tap_reset);
            o_cap   += int'(capture);
            o_shift += int'(shift);
            o_upd   += int'(update);
            o_rt    += int'(runtest);
            if ($countones({tap_reset, capture, shift, update, runtest}) > 1) o_proto++;
            if (!shift && tdi) o_proto++;
            if ((tap_reset || runtest || !bus.busy) && sel) o_proto++;
            if (bus.done) begin
                o_dones++;
                if (o_lat < 0) o_lat = c;
            end
            if (abort_at > 0 && c == abort_at + 1) o_abort_outs = any_out();
            bus.req = (c == repulse_at);
            rst     = (abort_at > 0) && (c == abort_at || c == abort_at + 1);
            if (abort_at > 0) begin
                if (c >= abort_at + 30) break;
            end else if (o_lat >= 0 && c >= o_lat + tail) begin
                break;
            end
        end
        bus.req = 1'b0;
        rst     = 1'b0;
    endtask

    int nz, first, b_after, b_next, c_next, got, dn;

    initial begin
        vt[0] = '{1'b0, 6'd32, 32'hA5A5_0F0F, 1'b1, 32'h0,         32'h4B4A_1E1E, 36, 32, 0};
        vt[1] = '{1'b0, 6'd8,  32'hFFFF_FFFF, 1'b0, 32'h0000_0053, 32'h0000_0053, 12,  8, 0};
        vt[2] = '{1'b1, 6'd0,  32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000,  8,  0, 4};
        vt[3] = '{1'b0, 6'd4,  32'h0000_0000, 1'b0, 32'hFFFF_FFF5, 32'h0000_0005,  8,  4, 0};
        vt[4] = '{1'b1, 6'd40, 32'h1234_5678, 1'b1, 32'h0,         32'h2468_ACF0, 40, 32, 4};
        vt[5] = '{1'b0, 6'd1,  32'h0000_0000, 1'b0, 32'h0000_0001, 32'h0000_0001,  5,  1, 0};
        vt[6] = '{1'b0, 6'd31, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h7FFF_FFFE, 35, 31, 0};

        bus.req = 1'b0; bus.cmd_rst = 1'b0; bus.len = '0; bus.wdata = '0;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 64'(any_out()), 64'd0);
        rst = 1'b0;
        nz = 0;
        repeat (20) begin
            @(negedge clk);
            if (any_out()) nz++;
        end
        chk("idle_quiet", 64'(nz), 64'd0);

        for (int i = 0; i < NV; i++) begin
            loop_mode = vt[i].loopm;
            tdo_seq   = vt[i].seq;
            run_scan(vt[i].crst, vt[i].ln, vt[i].wd, 0, 0);
            chk($sformatf("v%0d_latency", i), 64'(o_lat),   64'(vt[i].exp_lat + IDLE_ADD));
            chk($sformatf("v%0d_rdata", i),   64'(bus.rdata), 64'(vt[i].exp_rd));
            chk($sformatf("v%0d_shift", i),   64'(o_shift), 64'(vt[i].exp_shift));
            chk($sformatf("v%0d_trst", i),    64'(o_trst),  64'(vt[i].exp_trst));
            chk($sformatf("v%0d_capture", i), 64'(o_cap),   64'd1);
            chk($sformatf("v%0d_update", i),  64'(o_upd),   64'd1);
            chk($sformatf("v%0d_runtest", i), 64'(o_rt),    64'(IDLE_ADD));
            chk($sformatf("v%0d_busy1", i),   64'(o_busy1), 64'd1);
            chk($sformatf("v%0d_dones", i),   64'(o_dones), 64'd1);
            chk($sformatf("v%0d_protocol", i), 64'(o_proto), 64'd0);
        end

        // Second request during a len=16 scan must be dropped.
        loop_mode = 1'b1;
        run_scan(1'b0, 6'd16, 32'hDEAD_BEEF, 5, 0);
        chk("repulse_dones",   64'(o_dones), 64'd1);
        chk("repulse_latency", 64'(o_lat),   64'(20 + IDLE_ADD));
        chk("repulse_rdata",   64'(bus.rdata), 64'h7DDE);
        chk("repulse_protocol", 64'(o_proto), 64'd0);

        // RESET mid-scan: no done, everything cleared including old rdata.
        run_scan(1'b0, 6'd16, 32'h0F0F_1234, 0, 10);
        chk("abort_dones", 64'(o_dones), 64'd0);
        chk("abort_outs",  64'(o_abort_outs), 64'd0);
        chk("abort_rdata", 64'(bus.rdata), 64'd0);
        chk("abort_busy",  64'(bus.busy), 64'd0);

        // req held through done: accepted only once back in IDLE.
        dn = 6 + IDLE_ADD;
        first = -1; b_after = -1;
        @(negedge clk);
        bus.req = 1'b1; bus.cmd_rst = 1'b0; bus.len = 6'd2; bus.wdata = 32'h3;
        @(posedge clk);
        for (int c = 1; c <= dn + 1; c++) begin
            @(negedge clk);
            if (bus.done && first < 0) first = c;
            if (c == dn + 1) b_after = int'(bus.busy);
        end
        @(negedge clk);
        b_next = int'(bus.busy);
        c_next = int'(capture);
        bus.req = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            if (bus.done) got = 1;
        end
        chk("hold_first_done", 64'(first),   64'(dn));
        chk("hold_idle_gap",   64'(b_after), 64'd0);
        chk("hold_reaccept",   64'(b_next),  64'd1);
        chk("hold_capture",    64'(c_next),  64'd1);
        chk("hold_second_done", 64'(got),    64'd1);
        chk("hold_rdata",      64'(bus.rdata), 64'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jtag_scan_seq.md
Name: jtag_scan_seq

Overview:
- Single-clock sequencer that drives the user-register side of a BSCAN-style JTAG data register (jtag_rom and similar) from a simple command interface.
- Performs one DR scan per command: an optional TAP reset phase, then CAPTURE, SHIFT for LEN bits, then UPDATE.
- Drives TDI LSB-first from a write word and collects TDO into a read word.
- Sits between a host/test engine and the JTAG user chain. TCK is clk_p, so every strobe lasts exactly one clk_p cycle.

Parameters:
- W, 32, maximum scan length and data word width.
- LW, 6, width of LEN; must satisfy 2^LW > W.
- RST_CYCLES, 4, number of cycles TAP_RESET is held when a reset phase is requested.
- IDLE_CYCLES, 2, RUNTEST cycles after UPDATE (used only with the optional feature).

Ports:
- clk_p  in  1  clock; also the TCK of the target chain.
- RESET  in  1  synchronous, active-high reset of this block.
- req  in  1  command request; sampled only in IDLE.
- cmd_rst  in  1  with req: insert a TAP_RESET phase before CAPTURE.
- len  in  LW  scan length in bits, 0..W; values above W are clamped to W.
- wdata  in  W  bits shifted out on TDI, bit0 first.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when the scan completes.
- rdata  out  W  captured TDO bits; bit0 = first bit shifted; bits at and above len read 0.
- TAP_RESET  out  1  reset to the user chain.
- SEL  out  1  chain select.
- CAPTURE  out  1  capture strobe.
- SHIFT  out  1  shift enable.
- UPDATE  out  1  update strobe.
- RUNTEST  out  1  run-test/idle indicator.
- TDI  out  1  serial data to the chain.
- TDO  in  1  serial data from the chain.

Behaviour:
- Clocking and reset:
  - One clock, clk_p. RESET is synchronous and active-high.
  - On RESET, all outputs go to 0 (busy, done, rdata, TAP_RESET, SEL, CAPTURE, SHIFT, UPDATE, RUNTEST, TDI), the state goes to IDLE and internal counters clear.
  - RESET asserted mid-scan aborts the scan immediately. No done pulse is produced and the partial rdata is discarded (rdata = 0).
- All outputs are registered.
- States and transitions:
  - IDLE: on req=1, latch len (clamped), wdata and cmd_rst; busy=1 from the next cycle. Go to TRST if cmd_rst=1, else CAPT. req=0 stays in IDLE.
  - TRST: TAP_RESET=1 for exactly RST_CYCLES cycles, SEL=0, then CAPT.
  - CAPT: SEL=1, CAPTURE=1 for one cycle, then GAP.
  - GAP: SEL=1 with all strobes low for one cycle; the DUT presents the captured bit0 on TDO. Then SHIFT if len>0, else UPD.
  - SHIFT: SEL=1, SHIFT=1 for exactly len cycles.
    - TDI = wdata[k] during shift cycle k (k = 0..len-1).
    - TDO is sampled at the rising edge ending cycle k into shift register bit k.
    - When the bit counter reaches len-1, go to UPD.
  - UPD: SEL=1, UPDATE=1 for one cycle, TDI=0, then FIN.
  - FIN: rdata is loaded with the collected bits, upper bits zeroed. done=1 and busy=0 in this cycle, then return to IDLE.
- Latency, accept edge to done cycle:
  - len+4 cycles without TAP reset.
  - len+4+RST_CYCLES cycles with cmd_rst.
- Handshake and data rules:
  - req while busy=1 is ignored and not queued; the host re-issues the request after done.
  - req asserted in the same cycle as done is not accepted, because the block is not yet in IDLE; it is accepted the next cycle if still held.
  - rdata holds its value until the next FIN or RESET.
  - len=0: CAPT, GAP, UPD and FIN only; rdata=0; no SHIFT cycles.
  - len=W: full-word scan with no wrap; the bit counter is LW wide and never overflows.
- Outside CAPT through UPD, SEL=0, and TDI=0 whenever SHIFT=0.
- Exactly one of TAP_RESET, CAPTURE, SHIFT, UPDATE and RUNTEST is high in any cycle, or none is.

Optional Feature:
- Macro: JTAG_SCAN_IDLE_EN.
- Defined:
  - After UPD, an IDLE_RT state holds RUNTEST=1 (SEL=0) for IDLE_CYCLES cycles before FIN.
  - Latency increases by IDLE_CYCLES.
  - RESET during IDLE_RT aborts as in any other state.
- Undefined: no IDLE_RT state, RUNTEST is tied to 0, and latency is as stated above.

Test Plan:
- RESET held 10 cycles, then released with req=0 -> all outputs 0 and busy stays 0 for 20 cycles.
- req, len=32, wdata=32'hA5A5_0F0F, TDO looped to TDI via a 1-cycle register (bench model) -> CAPTURE 1 cycle, SHIFT exactly 32 cycles, UPDATE 1 cycle, done at accept+36, rdata equals wdata realigned by the loop delay (bench computes the expected value).
- len=8, TDO driven from a bench pattern 8'b1100_1010 (bit0 first) -> rdata=32'h0000_0053, SHIFT high exactly 8 cycles, done at accept+12.
- len=0, cmd_rst=1 -> TAP_RESET high exactly 4 cycles, then CAPTURE, then UPDATE, no SHIFT, rdata=0, done at accept+8.
- req pulsed again at accept+5 of a len=16 scan, and RESET asserted at accept+10 of another scan -> second req ignored with one done only; the aborted scan gives no done, all outputs 0, rdata=0.
- With JTAG_SCAN_IDLE_EN, len=4 -> RUNTEST high exactly 2 cycles after UPDATE, done at accept+10.
